// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one write-back pulse per op.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle 33x33 multiplier.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            wb_en,
  output logic            done,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: start is sampled only in IDLE; busy covers RUN and DONE; done/wb_en pulse for the DONE cycle.
  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        neg_q, neg_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, is_special;
  logic [31:0] spec_res;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] hi_step, lo_step;
  logic [63:0] prod, prod_s;
  logic [31:0] mul_res, div_raw, div_res, run_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [32:0] a_ext, b_ext;
  logic signed [63:0] fast_prod;
`endif

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    b_sgn    = is_div ? ~funct3[0] : (funct3 == 3'b001);
    a_neg    = a_sgn & rs1_data[31];
    b_neg    = b_sgn & rs2_data[31];
    a_mag    = a_neg ? (32'd0 - rs1_data) : rs1_data;
    b_mag    = b_neg ? (32'd0 - rs2_data) : rs2_data;
    div_zero = is_div && (rs2_data == 32'd0);
    div_ovf  = is_div && !funct3[0] && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    spec_res = 32'd0;
`ifdef MULDIV_FAST_MUL_EN
    a_ext     = $signed({a_neg, rs1_data});
    b_ext     = $signed({b_neg, rs2_data});
    fast_prod = a_ext * b_ext;
    is_special = div_zero || div_ovf || !is_div;
    if (!is_div) spec_res = (funct3[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
`else
    is_special = div_zero || div_ovf;
`endif
    if (div_zero)     spec_res = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
    else if (div_ovf) spec_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration: hi/lo hold {product upper, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {hi_q, lo_q[31]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    if (op_q[2]) begin
      hi_step = div_ge ? (div_shift[31:0] - opnd_q) : div_shift[31:0];
      lo_step = {lo_q[30:0], div_ge};
    end else begin
      hi_step = mul_sum[32:1];
      lo_step = {mul_sum[0], lo_q[31:1]};
    end
    prod    = {hi_step, lo_step};
    prod_s  = neg_q ? (64'd0 - prod) : prod;
    mul_res = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    div_raw = op_q[1] ? hi_step : lo_step;
    div_res = neg_q ? (32'd0 - div_raw) : div_raw;
    run_res = op_q[2] ? div_res : mul_res;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = funct3;
          rd_d   = rd;
          cnt_d  = 6'd0;
          hi_d   = 32'd0;
          opnd_d = is_div ? b_mag : a_mag;
          lo_d   = is_div ? a_mag : b_mag;
          // Remainder takes the dividend's sign; quotient and product take the xor.
          neg_d  = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
          if (is_special) begin
            state_d   = S_DONE;
            wb_data_d = spec_res;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_d == 6'd32) begin
          state_d   = S_DONE;
          wb_data_d = run_res;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 3'd0;
      opnd_q    <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      neg_q     <= 1'b0;
      rd_q      <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign wb_en     = done && (rd_q != 5'd0);
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;
  assign dbg_state = state_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative RV32M multiply/divide unit between the register-file read ports and the register-file write port.
- Captures `rs1_data`/`rs2_data`/`rd` on a start pulse, computes over multiple cycles while holding the pipeline via `busy`, then presents a one-cycle write-back (`wb_en`, `wb_rd`, `wb_data`) feeding the register file's `reg_write`/`rd`/`rd_data`.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; accepted only in IDLE.
- `funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data` in 32: operand A (multiplicand / dividend).
- `rs2_data` in 32: operand B (multiplier / divisor).
- `rd` in 5: destination register.
- `busy` out 1: high from the cycle after acceptance through the DONE cycle inclusive; the core stalls fetch/decode while high.
- `wb_en` out 1: one-cycle pulse, high only in DONE and only when `wb_rd != 0`.
- `done` out 1: one-cycle pulse in DONE, regardless of `wb_rd`.
- `wb_rd` out 5: captured `rd`.
- `wb_data` out 32: result, held stable from DONE until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN: on `start`, normal case.
  - IDLE -> DONE: on `start`, special case.
  - RUN -> DONE: when the iteration counter reaches 32.
  - DONE -> IDLE: unconditionally.
- Acceptance latches `funct3`, operands, and `rd`. `start` outside IDLE is ignored; no queueing.
- Multiply: 32-iteration shift-add on 64-bit magnitudes.
  - Operands are sign-converted per op: MULH both signed; MULHSU A signed, B unsigned; MULHU/MUL unsigned.
  - The product is negated at the end if the signs differ.
  - MUL returns bits [31:0]; the MULH variants return bits [63:32].
- Divide: 32-iteration restoring division on magnitudes with a 33-bit partial remainder.
  - Quotient sign = sign(A) xor sign(B), signed ops only.
  - Remainder sign = sign(A), signed ops only.
- Special cases, decided at acceptance and skipping RUN:
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): DIV -> 0x80000000, REM -> 0.
- Counter is 6 bits, cleared on acceptance, incremented each RUN cycle.
- Reset values: state IDLE, counter 0, `busy`=0, `done`=0, `wb_en`=0, `wb_rd`=0, `wb_data`=0, all internal operand/accumulator registers 0.

## Timing
- `start` in cycle 0, normal case:
  - `busy` high cycles 1–33.
  - RUN occupies cycles 1–32.
  - `done`/`wb_en` high in cycle 33 only.
  - IDLE in cycle 34.
- Special case: `busy`, `done`, `wb_en` high in cycle 1 only; IDLE in cycle 2.
- Back-to-back: a new `start` is accepted in the first IDLE cycle (cycle 34, or cycle 2 for special cases). `start` held high through DONE does not re-trigger until IDLE.
- `busy` is low in IDLE, including cycle 0. The issuing stage must drop `start` once `busy` rises.
- `rd`=0: computation runs fully; `done` pulses, `wb_en` stays 0.
- `rst` in any state, including mid-RUN or DONE: next cycle IDLE with all outputs at reset values; the in-flight result is discarded and no `wb_en` pulse occurs.
- `rst` and `start` together: `rst` wins and the request is dropped.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - All four multiply ops use a single-cycle combinational 33x33 signed multiplier and take the special-case path: IDLE -> DONE, latency 1, `busy` high cycle 1 only.
  - Divide is unchanged.
- Not defined: multiply is iterative (33-cycle `busy`, as above); no hardware multiplier is inferred.

## Test plan
- MUL 7 x 6, `rd`=5, `start` cycle 0 -> `wb_en`=1, `wb_rd`=5, `wb_data`=42 in cycle 33 (cycle 1 with `MULDIV_FAST_MUL_EN`); `busy` high exactly cycles 1–33 (resp. 1).
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV −7 / 2 -> 0xFFFFFFFD; REM −7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2; each with `done` in cycle 33.
- DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; each with `done` in cycle 1.
- DIVU with `rd`=0 -> `done` pulses in cycle 33, `wb_en` stays 0. A second `start` pulsed in cycle 10 is ignored and yields no extra `done`.
- `rst` asserted in cycle 15 of a DIV -> cycle 16: `busy`=0, `wb_data`=0, and no `done` within the following 40 cycles.
